pipe_stage_reg: RTL



---
 rtl/pipe_pkg.sv | 27 ++
 rtl/pipe_slot.sv | 73 +++++++
 rtl/pipe_stage_reg.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: default field widths,
// control-bundle bit positions and the per-slot operation encoding.
package pipe_pkg;

  localparam int DATA_W = 32;
  localparam int RD_W   = 5;
  localparam int CTRL_W = 4;

  // Control bundle bit positions (all active-high enables)
  localparam int CTRL_MEMWR   = 0;
  localparam int CTRL_MEMRD   = 1;
  localparam int CTRL_REGWR   = 2;
  localparam int CTRL_MEM2REG = 3;

  // What a storage slot does at the next edge
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_CLEAR = 2'd2
  } slot_op_e;

  // A beat moves across a valid/ready boundary
  function automatic logic xfer(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One valid+payload register. CLEAR turns the slot into a bubble: valid,
// rd and ctrl go to zero so downstream hazard logic sees no write enables;
// alu/wdata keep their old (don't-care) value.
module pipe_slot #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] d_alu,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [RD_W-1:0]   d_rd,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_alu,
  output logic [DATA_W-1:0] q_wdata,
  output logic [RD_W-1:0]   q_rd,
  output logic [CTRL_W-1:0] q_ctrl
);
  import pipe_pkg::*;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  // Next-state: clear wins over load; hold otherwise
  always_comb begin
    valid_d = valid_q;
    alu_d   = alu_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    if (op == OP_CLEAR) begin
      valid_d = 1'b0;
      rd_d    = '0;
      ctrl_d  = '0;
    end else if (op == OP_LOAD) begin
      valid_d = 1'b1;
      alu_d   = d_alu;
      wdata_d = d_wdata;
      rd_d    = d_rd;
      ctrl_d  = d_ctrl;
    end
  end

  // Slot storage, everything zero on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      alu_q   <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      alu_q   <= alu_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign q_valid = valid_q;
  assign q_alu   = alu_q;
  assign q_wdata = wdata_q;
  assign q_rd    = rd_q;
  assign q_ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, synchronous
// flush and an optional one-entry skid buffer. The main slot drives the
// outputs directly, so out_* are pure flop outputs. With SKID=1 in_ready
// comes from the skid valid flop, breaking the ready path through the stage.
module pipe_stage_reg #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int RD_W   = pipe_pkg::RD_W,
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_wdata,
  output logic [RD_W-1:0]   out_rd,
  output logic [CTRL_W-1:0] out_ctrl
);
  import pipe_pkg::*;

  logic              main_v, skid_v;
  logic [DATA_W-1:0] skid_alu, skid_wdata;
  logic [RD_W-1:0]   skid_rd;
  logic [CTRL_W-1:0] skid_ctrl;

  logic              in_xfer, out_xfer;
  slot_op_e          main_op, skid_op;
  logic              main_from_skid;

  logic [DATA_W-1:0] main_d_alu, main_d_wdata;
  logic [RD_W-1:0]   main_d_rd;
  logic [CTRL_W-1:0] main_d_ctrl;

  // Steering: decide what each slot does at the next edge
  always_comb begin
    in_xfer        = xfer(in_valid, in_ready);
    out_xfer       = xfer(main_v, out_ready);
    main_op        = OP_HOLD;
    skid_op        = OP_HOLD;
    main_from_skid = 1'b0;
    if (flush) begin
      // Kill both slots and ignore the concurrent input beat
      main_op = OP_CLEAR;
      skid_op = OP_CLEAR;
    end else if (SKID != 0) begin
      if (!main_v || out_xfer) begin
        if (skid_v) begin
          // Older skid beat advances first to keep order
          main_op        = OP_LOAD;
          main_from_skid = 1'b1;
          skid_op        = in_xfer ? OP_LOAD : OP_CLEAR;
        end else if (in_xfer) begin
          main_op = OP_LOAD;
        end else if (out_xfer) begin
          main_op = OP_CLEAR;
        end
      end else if (in_xfer) begin
        // Main is stuck: park the beat in the skid slot
        skid_op = OP_LOAD;
      end
    end else begin
      if (in_xfer) begin
        main_op = OP_LOAD;
      end else if (out_xfer) begin
        main_op = OP_CLEAR;
      end
    end
  end

  // Main slot source select: skid entry or fresh input
  always_comb begin
    main_d_alu   = in_alu;
    main_d_wdata = in_wdata;
    main_d_rd    = in_rd;
    main_d_ctrl  = in_ctrl;
    if (main_from_skid) begin
      main_d_alu   = skid_alu;
      main_d_wdata = skid_wdata;
      main_d_rd    = skid_rd;
      main_d_ctrl  = skid_ctrl;
    end
  end

  pipe_slot #(.DATA_W(DATA_W), .RD_W(RD_W), .CTRL_W(CTRL_W)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .op      (main_op),
    .d_alu   (main_d_alu),
    .d_wdata (main_d_wdata),
    .d_rd    (main_d_rd),
    .d_ctrl  (main_d_ctrl),
    .q_valid (main_v),
    .q_alu   (out_alu),
    .q_wdata (out_wdata),
    .q_rd    (out_rd),
    .q_ctrl  (out_ctrl)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_slot #(.DATA_W(DATA_W), .RD_W(RD_W), .CTRL_W(CTRL_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .op      (skid_op),
        .d_alu   (in_alu),
        .d_wdata (in_wdata),
        .d_rd    (in_rd),
        .d_ctrl  (in_ctrl),
        .q_valid (skid_v),
        .q_alu   (skid_alu),
        .q_wdata (skid_wdata),
        .q_rd    (skid_rd),
        .q_ctrl  (skid_ctrl)
      );
      // Registered ready: only the skid valid flop feeds it
      assign in_ready = !skid_v;
    end else begin : g_noskid
      logic unused_skid_op;
      assign unused_skid_op = (skid_op == OP_LOAD);
      assign skid_v         = 1'b0;
      assign skid_alu       = '0;
      assign skid_wdata     = '0;
      assign skid_rd        = '0;
      assign skid_ctrl      = '0;
      // Combinational ready: accept when main is empty or draining
      assign in_ready = !main_v || out_ready;
    end
  endgenerate

  assign out_valid = main_v;

endmodule
